// File: rtl/prog_run_ctrl.sv
// ============================================================================
// prog_run_ctrl : loads X9 machine code into imem, runs the core, reports status
// Revision 1.0
// ============================================================================
`default_nettype none

module prog_run_ctrl #(
   parameter int D          = 12,
   parameter int IW         = 9,
   parameter int CW         = 16,
   parameter int MAX_CYCLES = 4000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_start,
   input  logic          in_valid,
   input  logic [IW-1:0] in_word,
   input  logic          in_last,
   output logic          in_ready,
   output logic          imem_wr_en,
   output logic [D-1:0]  imem_wr_addr,
   output logic [IW-1:0] imem_wr_data,
   output logic          core_reset,
   input  logic          core_done,
   output logic [CW-1:0] run_cycles,
   output logic          busy,
   output logic          finished,
   output logic          timeout,
   output logic          overflow,
   input  logic          host_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } state_t;

   // The cycle whose count is MAX_CYCLES-1 is the last one the core gets.
   localparam logic [CW-1:0] TIMEOUT_AT = CW'(MAX_CYCLES - 1);
   localparam logic [CW-1:0] CYC_SAT    = {CW{1'b1}};
   localparam logic [D-1:0]  ADDR_TOP   = {D{1'b1}};

   state_t       state;
   logic [D-1:0] addr;

   assign in_ready     = (state == LOAD);
   assign imem_wr_en   = in_valid & in_ready;
   assign imem_wr_addr = addr;
   assign imem_wr_data = in_word;
   assign busy         = (state == LOAD) | (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         run_cycles <= '0;
         core_reset <= 1'b1;
         finished   <= 1'b0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               core_reset <= 1'b1;
               if (load_start) begin
                  state      <= LOAD;
                  addr       <= '0;
                  run_cycles <= '0;
                  finished   <= 1'b0;
                  timeout    <= 1'b0;
                  overflow   <= 1'b0;
               end
            end

            LOAD: begin
               if (in_valid) begin
                  addr <= addr + D'(1);
                  if (in_last) begin
                     state      <= RUN;
                     core_reset <= 1'b0;
                  end else if (addr == ADDR_TOP) begin
                     // Memory full with no end marker: refuse to run a truncated program.
                     state    <= HALT;
                     overflow <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (run_cycles != CYC_SAT) begin
                  run_cycles <= run_cycles + CW'(1);
               end
               if (core_done) begin
                  state      <= HALT;
                  finished   <= 1'b1;
                  core_reset <= 1'b1;
               end else if (run_cycles >= TIMEOUT_AT) begin
                  state      <= HALT;
                  timeout    <= 1'b1;
                  core_reset <= 1'b1;
               end
            end

            HALT: begin
               core_reset <= 1'b1;
               if (host_ack) begin
                  state <= IDLE;
               end
            end

            default: begin
               state      <= IDLE;
               core_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prog_run_ctrl.sv
// ============================================================================
// tb_prog_run_ctrl : directed bench for prog_run_ctrl (two parameter sets)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prog_run_ctrl;

   logic       clk = 1'b0;
   logic       reset, load_start, in_valid, in_last, core_done, host_ack;
   logic [8:0] in_word;

   logic        a_in_ready, a_wr_en, a_core_reset, a_busy, a_finished, a_timeout, a_overflow;
   logic [11:0] a_wr_addr;
   logic [8:0]  a_wr_data;
   logic [15:0] a_run_cycles;

   logic        b_in_ready, b_wr_en, b_core_reset, b_busy, b_finished, b_timeout, b_overflow;
   logic [2:0]  b_wr_addr;
   logic [8:0]  b_wr_data;
   logic [15:0] b_run_cycles;

   int n_vec = 0;
   int n_err = 0;
   int a_low = 0;
   int b_low = 0;
   logic [11:0] qa_addr[$];
   logic [8:0]  qa_data[$];
   logic [2:0]  qb_addr[$];
   logic [8:0]  qb_data[$];

   always #5 clk = ~clk;

   prog_run_ctrl #(.D(12), .IW(9), .CW(16), .MAX_CYCLES(20)) u_a (
      .clk(clk), .reset(reset), .load_start(load_start),
      .in_valid(in_valid), .in_word(in_word), .in_last(in_last), .in_ready(a_in_ready),
      .imem_wr_en(a_wr_en), .imem_wr_addr(a_wr_addr), .imem_wr_data(a_wr_data),
      .core_reset(a_core_reset), .core_done(core_done), .run_cycles(a_run_cycles),
      .busy(a_busy), .finished(a_finished), .timeout(a_timeout), .overflow(a_overflow),
      .host_ack(host_ack)
   );

   prog_run_ctrl #(.D(3), .IW(9), .CW(16), .MAX_CYCLES(5)) u_b (
      .clk(clk), .reset(reset), .load_start(load_start),
      .in_valid(in_valid), .in_word(in_word), .in_last(in_last), .in_ready(b_in_ready),
      .imem_wr_en(b_wr_en), .imem_wr_addr(b_wr_addr), .imem_wr_data(b_wr_data),
      .core_reset(b_core_reset), .core_done(core_done), .run_cycles(b_run_cycles),
      .busy(b_busy), .finished(b_finished), .timeout(b_timeout), .overflow(b_overflow),
      .host_ack(host_ack)
   );

   // Log every write and count core-released cycles, mid-cycle.
   always @(negedge clk) begin
      if (a_wr_en) begin
         qa_addr.push_back(a_wr_addr);
         qa_data.push_back(a_wr_data);
      end
      if (b_wr_en) begin
         qb_addr.push_back(b_wr_addr);
         qb_data.push_back(b_wr_data);
      end
      if (!a_core_reset) a_low <= a_low + 1;
      if (!b_core_reset) b_low <= b_low + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [8:0] w, input logic last);
      in_valid = 1'b1;
      in_word  = w;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   logic [8:0] w1 [4];
   logic [8:0] w2 [3];

   initial begin
      int ia, ib, la, lb, n;
      w1 = '{9'h101, 9'h0A2, 9'h1FF, 9'h003};
      w2 = '{9'h011, 9'h122, 9'h033};
      reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_word = '0; core_done = 1'b0; host_ack = 1'b0;
      tick();
      do_reset();

      chk("rst_core_reset", a_core_reset, 1);
      chk("rst_run_cycles", a_run_cycles, 0);
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_flags", {a_finished, a_timeout, a_overflow, a_wr_en}, 0);

      // Basic load of four words, core finishes on its 10th run cycle
      start_load();
      chk("load_in_ready", a_in_ready, 1);
      chk("load_busy", a_busy, 1);
      ia = qa_addr.size();
      la = a_low;
      for (int i = 0; i < 4; i++) send(w1[i], i == 3);
      chk("run_core_reset", a_core_reset, 0);
      repeat (9) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("basic_nwrites", qa_addr.size() - ia, 4);
      for (int i = 0; i < 4; i++) begin
         chk("basic_addr", qa_addr[ia + i], i);
         chk("basic_data", qa_data[ia + i], w1[i]);
      end
      chk("basic_low_cycles", a_low - la, 10);
      chk("basic_run_cycles", a_run_cycles, 10);
      chk("basic_finished", a_finished, 1);
      chk("basic_timeout", a_timeout, 0);
      chk("basic_core_reset", a_core_reset, 1);

      // HALT ignores load_start; host_ack returns to IDLE with flags held
      start_load();
      chk("halt_busy", a_busy, 0);
      chk("halt_in_ready", a_in_ready, 0);
      chk("halt_finished", a_finished, 1);
      host_ack = 1'b1;
      tick();
      host_ack = 1'b0;
      chk("idle_finished_held", a_finished, 1);
      start_load();
      chk("reload_finished", a_finished, 0);
      chk("reload_run_cycles", a_run_cycles, 0);
      chk("reload_in_ready", a_in_ready, 1);

      // Gappy valid, then let the run time out
      ia = qa_addr.size();
      for (int i = 0; i < 3; i++) begin
         send(w2[i], i == 2);
         if (i < 2) repeat (2) tick();
      end
      chk("gap_nwrites", qa_addr.size() - ia, 3);
      for (int i = 0; i < 3; i++) begin
         chk("gap_addr", qa_addr[ia + i], i);
         chk("gap_data", qa_data[ia + i], w2[i]);
      end
      la = a_low;
      n = 0;
      while (a_busy && n < 100) begin
         tick();
         n++;
      end
      chk("to_run_len", n, 20);
      chk("to_run_cycles", a_run_cycles, 20);
      chk("to_timeout", a_timeout, 1);
      chk("to_finished", a_finished, 0);
      chk("to_core_reset", a_core_reset, 1);
      chk("to_low_cycles", a_low - la, 20);

      // Reset during run cycle 3
      host_ack = 1'b1;
      tick();
      host_ack = 1'b0;
      start_load();
      send(9'h055, 1'b1);
      tick();
      tick();
      chk("mid_run_cycles", a_run_cycles, 2);
      do_reset();
      chk("abort_core_reset", a_core_reset, 1);
      chk("abort_run_cycles", a_run_cycles, 0);
      chk("abort_busy", a_busy, 0);
      chk("abort_in_ready", a_in_ready, 0);
      start_load();
      ia = qa_addr.size();
      send(9'h1AA, 1'b1);
      chk("restart_addr", qa_addr[ia], 0);

      // Small memory: fill it without an end marker
      do_reset();
      start_load();
      chk("ovf_in_ready", b_in_ready, 1);
      ib = qb_addr.size();
      lb = b_low;
      for (int i = 0; i < 8; i++) send(9'(i * 3 + 1), 1'b0);
      chk("ovf_nwrites", qb_addr.size() - ib, 8);
      for (int i = 0; i < 8; i++) begin
         chk("ovf_addr", qb_addr[ib + i], i);
         chk("ovf_data", qb_data[ib + i], i * 3 + 1);
      end
      chk("ovf_flag", b_overflow, 1);
      chk("ovf_busy", b_busy, 0);
      repeat (3) tick();
      chk("ovf_core_reset", b_core_reset, 1);
      chk("ovf_never_ran", b_low - lb, 0);
      chk("ovf_big_mem", a_overflow, 0);

      // Last word lands exactly on the top address
      do_reset();
      start_load();
      for (int i = 0; i < 8; i++) send(9'(i), i == 7);
      chk("top_last_ovf", b_overflow, 0);
      chk("top_last_busy", b_busy, 1);
      chk("top_last_core_reset", b_core_reset, 0);

      // Done and timeout on the same cycle
      do_reset();
      start_load();
      send(9'h001, 1'b1);
      repeat (4) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("sim_finished", b_finished, 1);
      chk("sim_timeout", b_timeout, 0);
      chk("sim_run_cycles", b_run_cycles, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Host-side counterpart to the X9 core's fetch path.
- Accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them sequentially into instruction memory starting at address 0.
- After loading, releases the core from reset and lets it run, counting cycles until the core raises done or a timeout expires.
- Holds the core in reset again and reports status to the host until the host acknowledges.

Parameters:
- D, 12, instruction-memory address width; matches the core program-counter width.
- IW, 9, machine-code word width.
- CW, 16, run-cycle counter width.
- MAX_CYCLES, 4000, run timeout in cycles; must be at most 2**CW-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  host request to begin a load. Sampled only in IDLE.
- in_valid  input  1  host word valid.
- in_word  input  IW  machine-code word.
- in_last  input  1  marks the final program word.
- in_ready  output  1  controller accepts a word this cycle.
- imem_wr_en  output  1  instruction-memory write strobe.
- imem_wr_addr  output  D  write address.
- imem_wr_data  output  IW  write data.
- core_reset  output  1  reset to the core, active-high, registered.
- core_done  input  1  done from the core.
- run_cycles  output  CW  cycles spent in RUN.
- busy  output  1  high in LOAD or RUN.
- finished  output  1  high in HALT after the core raised done.
- timeout  output  1  high in HALT after MAX_CYCLES expired.
- overflow  output  1  high in HALT after memory filled without in_last.
- host_ack  input  1  host releases HALT.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - State is IDLE and the address counter is 0.
  - run_cycles=0, core_reset=1.
  - in_ready, imem_wr_en, busy, finished, timeout and overflow are all 0.
- A reset asserted mid-load or mid-run aborts to IDLE on that edge. Memory contents already written are left as they are.
- States: IDLE, LOAD, RUN, HALT (2-bit encoding).
- IDLE:
  - core_reset=1, in_ready=0.
  - load_start=1 moves to LOAD next cycle, clears addr, run_cycles and all status flags.
- LOAD:
  - in_ready=1 and core_reset=1.
  - imem_wr_en = in_valid & in_ready, combinational. imem_wr_addr = addr and imem_wr_data = in_word, both combinational.
  - A word is accepted when in_valid=1 in LOAD. addr increments on acceptance; when in_valid=0 nothing changes.
  - Accepted word with in_last=1: move to RUN next cycle.
  - Accepted word with addr=2**D-1 and in_last=0: the word is still written. Set overflow and move to HALT; the core never runs.
  - Accepted word with addr=2**D-1 and in_last=1: normal transition to RUN; no overflow.
- RUN:
  - core_reset=0; the registered output is low during every RUN cycle.
  - run_cycles increments by 1 each RUN cycle and saturates at 2**CW-1.
  - core_done=1 moves to HALT and sets finished. That cycle is counted.
  - If core_done=0 and run_cycles reaches MAX_CYCLES-1 in the current cycle, move to HALT and set timeout.
  - If core_done and timeout occur in the same cycle, finished wins; timeout stays 0.
- HALT:
  - core_reset=1. Flags and run_cycles are held.
  - load_start is ignored.
  - host_ack=1 moves to IDLE. Flags are held until the next load_start.
- busy = (state==LOAD) | (state==RUN).
- Latency: first RUN cycle is the cycle after the last word is accepted. The status flag is visible the cycle after the terminating event.

Test Plan:
- Basic load and run:
  - Stimulus: reset, load_start, 4 words 0x101,0x0A2,0x1FF,0x003 back-to-back with in_last on the 4th; core_done raised on the 10th RUN cycle.
  - Required: writes to addr 0..3 with matching data; core_reset low for exactly 10 cycles; run_cycles=10; finished=1.
- Gappy valid:
  - Stimulus: 3 words with in_valid low for 2 cycles between each.
  - Required: exactly 3 imem_wr_en pulses at addrs 0,1,2; addr does not advance on idle cycles.
- Timeout:
  - Stimulus: MAX_CYCLES=20, core_done never asserted.
  - Required: HALT after 20 RUN cycles; run_cycles=20; timeout=1; finished=0; core_reset returns to 1.
- Overflow:
  - Stimulus: D=3, stream 8 words with no in_last.
  - Required: 8 writes at addrs 0..7; overflow=1; core_reset never deasserts.
- Simultaneous events:
  - Stimulus: MAX_CYCLES=5, core_done=1 on RUN cycle 5.
  - Required: finished=1, timeout=0, run_cycles=5.
- Reset mid-op and HALT handshake:
  - Stimulus: reset during RUN cycle 3.
  - Required: next cycle IDLE, core_reset=1, run_cycles=0.
  - Stimulus: in HALT, load_start without host_ack.
  - Required: ignored.
  - Stimulus: host_ack then load_start.
  - Required: new load starts at addr 0.
